stream_mux: RTL and testbench

//  N-input, WIDTH-bit stream selector with valid/ready handshake and one registered output stage.

---
 rtl/stream_mux_pkg.sv | 18 +
 rtl/stream_mux_rr_arbiter.sv | 43 ++++
 rtl/stream_mux.sv | 120 ++++++++++++
 tb/tb_stream_mux.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux block: mode encodings and a constant-function
// helper for parameter checks.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, usable at elaboration time.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping at N.
// The wrap is handled by scanning a doubled request vector with the low part masked off.
module stream_mux_rr_arbiter #(
  parameter int unsigned N     = 10,
  parameter int unsigned PTR_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] start;
  logic [2*N-1:0]   mask;
  logic [2*N-1:0]   cand;
  logic             found;

  assign start = (32'(ptr) >= N - 1) ? '0 : ptr + PTR_W'(1);

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      mask[i] = (i >= 32'(start));
    end
  end

  assign cand = {req, req} & mask;

  // Lowest set bit of the masked double vector is the next channel in rotation.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (cand[i] && !found) begin
        found        = 1'b1;
        gnt[i % N]   = 1'b1;
        idx          = PTR_W'(i % N);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-input stream selector with valid/ready flow control, fixed or round-robin channel choice,
// one registered output stage, source tagging and an out-of-range select flag.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_IN  = 10,
  parameter int unsigned SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  if (N_IN < 2 || N_IN > 16) begin : gen_bad_n_in
    $error("stream_mux: N_IN must lie in 2..16");
  end
  if (SEL_W < clog2(N_IN)) begin : gen_bad_sel_w
    $error("stream_mux: SEL_W too narrow to index N_IN channels");
  end

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;

  logic             load;
  logic             sel_ok;
  logic             xfer;
  logic [N_IN-1:0]  fixed_gnt;
  logic [N_IN-1:0]  rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N_IN-1:0]  gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] mux_data;

  assign load   = !valid_q || out_ready;
  assign sel_ok = 32'(sel) < N_IN;

  always_comb begin
    fixed_gnt = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      fixed_gnt[k] = sel_ok && (32'(sel) == k) && in_valid[k];
    end
  end

  stream_mux_rr_arbiter #(
    .N     (N_IN),
    .PTR_W (SEL_W)
  ) u_rr_arbiter (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  assign gnt     = (mode == MODE_RR) ? rr_gnt : fixed_gnt;
  assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;

  // Reset gating keeps any handshake from completing in the reset cycle.
  assign in_ready = rst ? '0 : (gnt & {N_IN{load}});
  assign xfer     = |in_ready;

  always_comb begin
    mux_data = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      mux_data = mux_data | (in_data[k*WIDTH +: WIDTH] & {WIDTH{gnt[k]}});
    end
  end

  always_comb begin
    data_d   = data_q;
    src_d    = src_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = (mode == MODE_FIXED) && !sel_ok;
    if (load) begin
      valid_d = xfer;
      if (xfer) begin
        data_d = mux_data;
        src_d  = gnt_idx;
        if (mode == MODE_RR) begin
          rr_ptr_d = gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      src_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= SEL_W'(N_IN - 1);
      err_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      src_q    <= src_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed vector table, hand-written corner sequences
// and randomized traffic compared against a transaction-level reference model.
module tb_stream_mux;

  localparam int N = 10;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [3:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [3:0]     out_src;
  logic           out_valid;
  logic           out_ready;
  logic           sel_err;

  logic [W-1:0]   word [N];

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int k = 0; k < N; k++) begin
      in_data[k*W +: W] = word[k];
    end
  end

  stream_mux #(
    .WIDTH (W),
    .N_IN  (N),
    .SEL_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] last_rdy;

  // Reference model state: the word held by the output stage and the last RR winner.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic [3:0]   m_src   = '0;
  int           m_ptr   = N - 1;
  logic         m_err   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel that should complete a handshake this cycle, or -1.
  function automatic int pick();
    int k;
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    if (mode == 1'b0) begin
      if (int'(sel) < N) begin
        if (in_valid[sel]) return int'(sel);
      end
      return -1;
    end
    for (int off = 1; off <= N; off++) begin
      k = (m_ptr + off) % N;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  // One clock cycle: drive at negedge, check ready, clock, check registered outputs.
  task automatic step(input logic r, input logic md, input logic [3:0] s,
                      input logic [N-1:0] v, input logic rdy);
    int k;
    rst       = r;
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = rdy;
    #1;
    k        = pick();
    last_rdy = in_ready;
    chk("in_ready", 32'(in_ready), (k >= 0) ? (32'd1 << k) : 32'd0);
    if (r) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = '0;
      m_ptr   = N - 1;
      m_err   = 1'b0;
    end else begin
      m_err = !md && (int'(s) >= N);
      if (k >= 0) begin
        m_valid = 1'b1;
        m_data  = word[k];
        m_src   = 4'(k);
        if (md) m_ptr = k;
      end else if (!m_valid || rdy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_src",   32'(out_src),   32'(m_src));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("sel_err",   32'(sel_err),   32'(m_err));
    @(negedge clk);
  endtask

  typedef struct {
    logic         r;
    logic         m;
    logic [3:0]   s;
    logic [N-1:0] v;
    logic         rdy;
    logic [N-1:0] e_rdy;
    logic         e_val;
    logic [3:0]   e_src;
    logic [W-1:0] e_data;
    logic         e_err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    for (int k = 0; k < N; k++) word[k] = (k == 3) ? 16'hBEEF : (16'hA000 | 16'(k));
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b0;

    //          r  m  sel  valid     rdy  e_rdy     val src e_data    err
    tbl[0]  = '{0, 0, 3,  10'h3FF, 1, 10'h008, 1, 3, 16'hBEEF, 0};
    tbl[1]  = '{0, 0, 12, 10'h3FF, 1, 10'h000, 0, 3, 16'hBEEF, 1};
    tbl[2]  = '{0, 0, 12, 10'h3FF, 0, 10'h000, 0, 3, 16'hBEEF, 1};
    tbl[3]  = '{0, 0, 5,  10'h3FF, 0, 10'h020, 1, 5, 16'hA005, 0};
    tbl[4]  = '{0, 0, 6,  10'h3FF, 0, 10'h000, 1, 5, 16'hA005, 0};
    tbl[5]  = '{0, 1, 0,  10'h3FF, 1, 10'h001, 1, 0, 16'hA000, 0};
    tbl[6]  = '{0, 1, 0,  10'h3FF, 1, 10'h002, 1, 1, 16'hA001, 0};
    tbl[7]  = '{0, 1, 0,  10'h204, 1, 10'h004, 1, 2, 16'hA002, 0};
    tbl[8]  = '{0, 1, 0,  10'h204, 0, 10'h000, 1, 2, 16'hA002, 0};
    tbl[9]  = '{0, 1, 0,  10'h204, 1, 10'h200, 1, 9, 16'hA009, 0};
    tbl[10] = '{0, 1, 0,  10'h000, 1, 10'h000, 0, 9, 16'hA009, 0};
    tbl[11] = '{1, 1, 0,  10'h3FF, 1, 10'h000, 0, 0, 16'h0000, 0};
    tbl[12] = '{0, 1, 12, 10'h3FF, 1, 10'h001, 1, 0, 16'hA000, 0};
    tbl[13] = '{0, 0, 15, 10'h3FF, 1, 10'h000, 0, 0, 16'hA000, 1};

    @(negedge clk);
    step(1'b1, 1'b0, 4'd0, 10'h3FF, 1'b1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data",  32'(out_data),  32'd0);
    chk("reset_out_src",   32'(out_src),   32'd0);
    chk("reset_sel_err",   32'(sel_err),   32'd0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].rdy);
      chk($sformatf("vec%0d_in_ready", i),  32'(last_rdy),  32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_val));
      chk($sformatf("vec%0d_out_src", i),   32'(out_src),   32'(tbl[i].e_src));
      chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tbl[i].e_data));
      chk($sformatf("vec%0d_sel_err", i),   32'(sel_err),   32'(tbl[i].e_err));
    end

    // Round-robin over all channels wraps after the last one.
    step(1'b1, 1'b1, 4'd0, 10'h3FF, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 4'd0, 10'h3FF, 1'b1);
      chk("rr_wrap_src", 32'(out_src), 32'(i % 10));
    end

    // Two requesters with a toggling consumer: sources alternate, stall holds everything.
    step(1'b1, 1'b1, 4'd0, 10'h3FF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'd0, 10'h204, (i % 2) == 0);
      chk("rr_alt_src", 32'(out_src), ((i / 2) % 2 != 0) ? 32'd9 : 32'd2);
      chk("rr_alt_data", 32'(out_data), ((i / 2) % 2 != 0) ? 32'hA009 : 32'hA002);
      if (i % 2 != 0) chk("rr_alt_stall_rdy", 32'(last_rdy), 32'd0);
    end

    // Back-pressure: held word stays put and the pointer does not move.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'd0, 10'h3FF, 1'b0);
      chk("bp_src", 32'(out_src), 32'd9);
      chk("bp_data", 32'(out_data), 32'hA009);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_rdy", 32'(last_rdy), 32'd0);
    end
    step(1'b0, 1'b1, 4'd0, 10'h3FF, 1'b1);
    chk("bp_next_src", 32'(out_src), 32'd0);

    // Reset while a word is held and sel_err is set.
    step(1'b0, 1'b0, 4'd12, 10'h3FF, 1'b0);
    chk("pre_rst_err", 32'(sel_err), 32'd1);
    step(1'b1, 1'b1, 4'd0, 10'h3FF, 1'b1);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", 32'(out_data), 32'd0);
    chk("rst_mid_err", 32'(sel_err), 32'd0);
    chk("rst_mid_rdy", 32'(last_rdy), 32'd0);
    step(1'b0, 1'b1, 4'd0, 10'h3FF, 1'b1);
    chk("rst_restart_src", 32'(out_src), 32'd0);

    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) word[k] = 16'($urandom);
      step($urandom_range(0, 39) == 0, 1'($urandom), 4'($urandom_range(0, 15)),
           10'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
